// File: rtl/div_ctrl.sv
// div_ctrl: sequencer between the EX stage and an iterative unsigned divider.
// Optional single-entry result fuse enabled by defining DIV_CTRL_FUSE_EN.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [7:0]  ex_opcode,
    input  logic [63:0] ex_op1,
    input  logic [63:0] ex_op2,
    input  logic        ex_flush,
    output logic        ex_ready,
    output logic        stall_req,
    output logic        core_start,
    output logic [63:0] core_op1,
    output logic [63:0] core_op2,
    input  logic        core_done,
    input  logic [63:0] core_quot,
    input  logic [63:0] core_rem,
    output logic        wb_valid,
    output logic [63:0] wb_data,
    input  logic        wb_ready
);

    localparam logic [7:0] OP_DIV   = 8'h01;
    localparam logic [7:0] OP_DIVU  = 8'h02;
    localparam logic [7:0] OP_REM   = 8'h03;
    localparam logic [7:0] OP_REMU  = 8'h04;
    localparam logic [7:0] OP_DIVW  = 8'h05;
    localparam logic [7:0] OP_DIVUW = 8'h06;
    localparam logic [7:0] OP_REMW  = 8'h07;
    localparam logic [7:0] OP_REMUW = 8'h08;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  op_q;
    logic        s1_q, s2_q;
    logic [2:0]  fin, fq;
    logic [63:0] a1, a2, m1, m2;
    logic        dz, ovf, hit, accept;
    logic [63:0] hit_data;

    // {signed, word, rem}
    function automatic logic [2:0] decode(input logic [7:0] op);
        case (op)
            OP_DIV:   return 3'b100;
            OP_DIVU:  return 3'b000;
            OP_REM:   return 3'b101;
            OP_REMU:  return 3'b001;
            OP_DIVW:  return 3'b110;
            OP_DIVUW: return 3'b010;
            OP_REMW:  return 3'b111;
            OP_REMUW: return 3'b011;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic logic [63:0] wext(input logic [63:0] v, input logic w);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    // Apply sign rules to unsigned core results, pick quot/rem, word-extend.
    function automatic logic [63:0] fixup(input logic [63:0] q, input logic [63:0] r,
                                          input logic [2:0] f, input logic s1,
                                          input logic s2);
        logic [63:0] qq, rr;
        qq = (f[2] && (s1 ^ s2)) ? -q : q;
        rr = (f[2] && s1) ? -r : r;
        return wext(f[0] ? rr : qq, f[1]);
    endfunction

    assign fin    = decode(ex_opcode);
    assign fq     = decode(op_q);
    assign accept = (state == IDLE) && ex_valid && !ex_flush;

    // Operand preparation and special-case detection for the op at the EX port.
    always_comb begin
        a1 = ex_op1;
        a2 = ex_op2;
        if (fin[1]) begin
            a1 = fin[2] ? {{32{ex_op1[31]}}, ex_op1[31:0]} : {32'h0, ex_op1[31:0]};
            a2 = fin[2] ? {{32{ex_op2[31]}}, ex_op2[31:0]} : {32'h0, ex_op2[31:0]};
        end
        m1  = (fin[2] && a1[63]) ? -a1 : a1;
        m2  = (fin[2] && a2[63]) ? -a2 : a2;
        dz  = (a2 == 64'h0);
        ovf = fin[2] && (a2 == {64{1'b1}}) &&
              (a1 == (fin[1] ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    end

`ifdef DIV_CTRL_FUSE_EN
    logic [63:0] e_op1, e_op2, e_quot, e_rem, a1_q, a2_q;
    logic        e_sgn, e_word, e_valid;

    assign hit = e_valid && (e_op1 == a1) && (e_op2 == a2) &&
                 (e_sgn == fin[2]) && (e_word == fin[1]);
    assign hit_data = fixup(e_quot, e_rem, fin, a1[63], a2[63]);

    // Fuse entry: refreshed on every core completion, dropped on reset/flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= 1'b0;
            e_op1   <= '0;
            e_op2   <= '0;
            e_quot  <= '0;
            e_rem   <= '0;
            e_sgn   <= 1'b0;
            e_word  <= 1'b0;
            a1_q    <= '0;
            a2_q    <= '0;
        end else if (ex_flush) begin
            e_valid <= 1'b0;
        end else begin
            if (accept) begin
                a1_q <= a1;
                a2_q <= a2;
            end
            if (state == BUSY && core_done) begin
                e_op1   <= a1_q;
                e_op2   <= a2_q;
                e_sgn   <= fq[2];
                e_word  <= fq[1];
                e_quot  <= core_quot;
                e_rem   <= core_rem;
                e_valid <= 1'b1;
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (dz || ovf || hit) ? DONE : BUSY;
            BUSY: if (core_done) state_nx = DONE;
            DONE: if (wb_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (ex_flush) state_nx = IDLE;
    end

    // Outputs decoded from state.
    always_comb begin
        ex_ready   = (state == IDLE);
        core_start = (state == BUSY);
        wb_valid   = (state == DONE);
        stall_req  = (state != IDLE) || (ex_valid && state == IDLE);
    end

    // Datapath: capture op on accept, produce result on bypass or completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            core_op1 <= '0;
            core_op2 <= '0;
            wb_data  <= '0;
        end else if (!ex_flush) begin
            if (accept) begin
                op_q     <= ex_opcode;
                s1_q     <= a1[63];
                s2_q     <= a2[63];
                core_op1 <= m1;
                core_op2 <= m2;
                if (dz)
                    wb_data <= wext(fin[0] ? a1 : {64{1'b1}}, fin[1]);
                else if (ovf)
                    wb_data <= wext(fin[0] ? 64'h0 : a1, fin[1]);
                else if (hit)
                    wb_data <= hit_data;
            end else if (state == BUSY && core_done) begin
                wb_data <= fixup(core_quot, core_rem, fq, s1_q, s2_q);
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural multi-cycle divider core.
module tb_div_ctrl;

    localparam logic [7:0] OP_DIV   = 8'h01;
    localparam logic [7:0] OP_DIVU  = 8'h02;
    localparam logic [7:0] OP_REM   = 8'h03;
    localparam logic [7:0] OP_REMU  = 8'h04;
    localparam logic [7:0] OP_DIVW  = 8'h05;
    localparam logic [7:0] OP_DIVUW = 8'h06;
    localparam logic [7:0] OP_REMW  = 8'h07;

    logic        clk = 0;
    logic        rst = 1;
    logic        ex_valid = 0;
    logic [7:0]  ex_opcode = 0;
    logic [63:0] ex_op1 = 0, ex_op2 = 0;
    logic        ex_flush = 0;
    logic        ex_ready, stall_req, core_start;
    logic [63:0] core_op1, core_op2;
    logic        core_done = 0;
    logic [63:0] core_quot = 0, core_rem = 0;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic        wb_ready = 0;

    int checks = 0;
    int errors = 0;
    int lat = 3;
    int cnt = 0;
    logic fired = 0;
    int start_cycles = 0;
    int n, s0;
    logic exp_hit;

    div_ctrl dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_flush(ex_flush),
        .ex_ready(ex_ready), .stall_req(stall_req),
        .core_start(core_start), .core_op1(core_op1), .core_op2(core_op2),
        .core_done(core_done), .core_quot(core_quot), .core_rem(core_rem),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_ready(wb_ready)
    );

    always #5 clk = ~clk;

    // Divider core model: done pulse after lat cycles of core_start.
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start) start_cycles <= start_cycles + 1;
        if (core_start && !fired) begin
            if (cnt == lat) begin
                core_done <= 1'b1;
                core_quot <= (core_op2 == 0) ? '1 : core_op1 / core_op2;
                core_rem  <= (core_op2 == 0) ? core_op1 : core_op1 % core_op2;
                fired     <= 1'b1;
                cnt       <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else if (!core_start) begin
            fired <= 1'b0;
            cnt   <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        ex_valid  = 1;
        ex_opcode = op;
        ex_op1    = a;
        ex_op2    = b;
        @(negedge clk);
        ex_valid  = 0;
    endtask

    task automatic wait_wb(output int cyc);
        cyc = 0;
        while (wb_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("wb_valid_timeout", {63'h0, wb_valid}, 64'h1);
    endtask

    task automatic retire();
        wb_ready = 1;
        @(negedge clk);
        wb_ready = 0;
        chk("idle_after_wb", {63'h0, ex_ready}, 64'h1);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ex_ready", {63'h0, ex_ready}, 64'h1);
        chk("rst_stall", {63'h0, stall_req}, 64'h0);
        chk("rst_core_start", {63'h0, core_start}, 64'h0);
        chk("rst_core_op1", core_op1, 64'h0);
        chk("rst_core_op2", core_op2, 64'h0);
        chk("rst_wb_valid", {63'h0, wb_valid}, 64'h0);
        chk("rst_wb_data", wb_data, 64'h0);
        rst = 0;

        // stall_req while an op is presented in IDLE
        @(negedge clk);
        ex_valid = 1; ex_opcode = OP_DIV; ex_op1 = 64'hFFFF_FFFF_FFFF_FFF9; ex_op2 = 2;
        #1 chk("stall_on_valid", {63'h0, stall_req}, 64'h1);
        @(negedge clk);
        ex_valid = 0;
        chk("busy_core_start", {63'h0, core_start}, 64'h1);
        chk("busy_core_op1", core_op1, 64'd7);
        chk("busy_core_op2", core_op2, 64'd2);
        chk("busy_ex_ready", {63'h0, ex_ready}, 64'h0);
        wait_wb(n);
        chk("div_m7_2", wb_data, 64'hFFFF_FFFF_FFFF_FFFD);
        retire();

        issue(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        wait_wb(n);
        chk("rem_m7_2", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
        retire();

        // divide by zero bypass
        s0 = start_cycles;
        issue(OP_DIVU, 64'd100, 64'd0);
        chk("divu0_wb_next", {63'h0, wb_valid}, 64'h1);
        chk("divu0_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
        retire();
        issue(OP_REMU, 64'd100, 64'd0);
        chk("remu0_wb_next", {63'h0, wb_valid}, 64'h1);
        chk("remu0_data", wb_data, 64'd100);
        retire();
        chk("div0_no_start", 64'(start_cycles - s0), 64'h0);

        // signed overflow bypass
        issue(OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ovf64_wb_next", {63'h0, wb_valid}, 64'h1);
        chk("ovf64_data", wb_data, 64'h8000_0000_0000_0000);
        retire();
        issue(OP_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
        chk("ovfw_data", wb_data, 64'hFFFF_FFFF_8000_0000);
        retire();
        issue(OP_REMW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
        chk("ovfw_rem", wb_data, 64'h0);
        retire();
        chk("ovf_no_start", 64'(start_cycles - s0), 64'h0);

        // DIVUW sign-extension and backpressure
        issue(OP_DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd1);
        wait_wb(n);
        for (int i = 0; i < 5; i++) begin
            chk("divuw_hold_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFE);
            chk("divuw_hold_valid", {63'h0, wb_valid}, 64'h1);
            @(negedge clk);
        end
        retire();

        // flush mid-BUSY
        lat = 30;
        issue(OP_DIV, 64'd100, 64'd7);
        repeat (9) @(negedge clk);
        chk("flush_pre_busy", {63'h0, core_start}, 64'h1);
        ex_flush = 1;
        @(negedge clk);
        ex_flush = 0;
        chk("flush_core_start", {63'h0, core_start}, 64'h0);
        chk("flush_wb_valid", {63'h0, wb_valid}, 64'h0);
        chk("flush_idle", {63'h0, ex_ready}, 64'h1);
        repeat (3) @(negedge clk);
        chk("flush_no_wb", {63'h0, wb_valid}, 64'h0);
        lat = 3;
        issue(OP_DIV, 64'd9, 64'd3);
        wait_wb(n);
        chk("div_9_3", wb_data, 64'd3);
        retire();

        // back-to-back same operands
        issue(OP_DIV, 64'd17, 64'd5);
        wait_wb(n);
        chk("div_17_5", wb_data, 64'd3);
        retire();
        s0 = start_cycles;
        issue(OP_REM, 64'd17, 64'd5);
        wait_wb(n);
        chk("rem_17_5", wb_data, 64'd2);
        retire();
`ifdef DIV_CTRL_FUSE_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif
        chk("rem_17_5_no_start", {63'h0, (start_cycles == s0)}, {63'h0, exp_hit});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset (`ysyx22040228_RSTENA = 1).
REQ-003 SHALL have port ex_valid  input  1  EX stage presents a div/rem op.
REQ-004 SHALL have port ex_opcode  input  8  opcode: `INST_DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW.
REQ-005 SHALL have ports ex_op1 (dividend, rs1) and ex_op2 (divisor, rs2), each input 64.
REQ-006 SHALL have port ex_flush  input  1  aborts any in-flight op.
REQ-007 SHALL have port ex_ready  output  1  op accepted this cycle when ex_valid && ex_ready.
REQ-008 SHALL have port stall_req  output  1  pipeline hold request.
REQ-009 SHALL have ports core_start (output 1, level), core_op1 and core_op2 (output 64 each, unsigned magnitudes).
REQ-010 SHALL have ports core_done (input 1), core_quot and core_rem (input 64 each, unsigned results).
REQ-011 SHALL have ports wb_valid (output 1), wb_data (output 64) and wb_ready (input 1).

Function
REQ-012 SHALL implement FSM IDLE, BUSY, DONE; ex_ready=1 only in IDLE.
REQ-013 SHALL, on accept in IDLE, register opcode, operand signs, and word/signed flags.
REQ-014 SHALL, for W ops, use op[31:0] sign-extended (signed) or zero-extended (unsigned) as operands.
REQ-015 SHALL, for signed ops, drive core_op1/core_op2 with two's-complement magnitudes; for unsigned ops, drive the raw values.
REQ-016 SHALL, on divisor zero, bypass the core: quotient = all ones, remainder = dividend; IDLE->DONE, wb_valid one cycle after accept.
REQ-017 SHALL, on signed overflow (most-negative / -1 at 64 or 32 bits), bypass the core: quotient = dividend, remainder = 0; IDLE->DONE.
REQ-018 SHALL otherwise enter BUSY and hold core_start=1 and core operands stable until core_done.
REQ-019 SHALL, on core_done in BUSY, latch the result and go to DONE the next cycle; core_start SHALL be 0 in DONE.
REQ-020 SHALL negate the quotient when dividend and divisor signs differ (signed ops only).
REQ-021 SHALL give the remainder the sign of the dividend (signed ops only).
REQ-022 SHALL sign-extend bit 31 of the selected result to 64 bits for all W ops, including DIVUW and REMUW.
REQ-023 SHALL hold wb_valid=1 and wb_data stable in DONE until wb_ready; on wb_ready, return to IDLE.
REQ-024 SHALL assert stall_req = (state != IDLE) || (ex_valid && state == IDLE && result not available in the same cycle).
REQ-025 SHALL, on ex_flush in any state, return to IDLE next cycle with core_start=0 and wb_valid=0, and discard the result.
REQ-026 SHALL let ex_flush take priority over a same-cycle core_done or wb_ready.
REQ-027 SHALL ignore core_done outside BUSY.

Reset
REQ-028 SHALL, on rst, set state=IDLE, ex_ready=1, stall_req=0, core_start=0, core_op1/core_op2=0, wb_valid=0, wb_data=0, and clear the fuse entry.
REQ-029 SHALL, on rst mid-operation, drop the in-flight op; core_start SHALL be 0 the cycle after.

Configuration
REQ-030 SHALL honour macro DIV_CTRL_FUSE_EN.
REQ-031 SHALL, when the macro is defined, keep one entry {op1, op2, signed, word, quot, rem, valid}, written on each core completion.
REQ-032 SHALL, when the macro is defined, treat an accepted op as a fuse hit if op1, op2, signed and word all match a valid entry; a hit goes IDLE->DONE with no core_start, using the stored quot/rem.
REQ-033 SHALL invalidate the fuse entry on rst or ex_flush.
REQ-034 SHALL, when the macro is undefined, contain no entry logic; every non-special op uses the core.

Verification
REQ-035 SHALL cover DIV 0xFFFFFFFFFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFFFFFFFFFD (-3); REM -7 % 2 -> 0xFFFFFFFFFFFFFFFF (-1).
REQ-036 SHALL cover DIVU 100 / 0 -> 0xFFFFFFFFFFFFFFFF with no core_start; REMU 100 % 0 -> 100; wb_valid one cycle after accept.
REQ-037 SHALL cover DIV 0x8000000000000000 / -1 -> 0x8000000000000000; DIVW 0x80000000 / 0xFFFFFFFF -> 0xFFFFFFFF80000000; REMW of the same -> 0.
REQ-038 SHALL cover DIVUW 0xFFFFFFFE / 1 -> 0xFFFFFFFFFFFFFFFE (sign-extended); wb_ready held low 5 cycles -> wb_data stable throughout.
REQ-039 SHALL cover ex_flush asserted 10 cycles into BUSY -> IDLE next cycle, core_start=0, no wb_valid; the following DIV 9/3 -> 3.
REQ-040 SHALL cover, with DIV_CTRL_FUSE_EN defined, DIV 17/5 then REM 17/5 -> 3 then 2, with the second op issuing no core_start; with the macro undefined, both ops use the core.
